// File: rtl/m_acc_pkg.sv
// m_acc_pkg: shared types and helpers for the m_acc_mac multiply-accumulate block.
//   state_t  : batch controller states (IDLE, ACCUM, HOLD)
//   sat_max  : largest signed value representable in w bits
//   sat_min  : smallest signed value representable in w bits
package m_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Both helpers work in 64-bit space, which covers any accumulator up to
  // 64 bits. Callers truncate to their own width with a size cast.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/m_acc_mac_if.sv
// m_acc_mac_if: operand and result handshake bundle for m_acc_mac.
//   in_valid/in_ready : operand pair transfer (in_a, in_b signed DATA_W)
//   out_valid/out_ready : result transfer (out_acc signed ACC_W, out_ovf)
// Modports:
//   master : operand source / result sink (testbench or upstream logic)
//   slave  : the accumulator block
interface m_acc_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

endinterface

// File: rtl/m_sat_add.sv
// m_sat_add: combinational ACC_W-bit signed adder with optional saturation.
//   a, b : signed addends
//   sat  : 1 = clamp to the signed range on overflow, 0 = two's-complement wrap
//   sum  : signed result (clamped or wrapped)
//   ovf  : signed overflow of the raw a+b addition
module m_sat_add
  import m_acc_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  input  logic                    sat,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

  logic signed [ACC_W-1:0] raw;

  // Overflow can only push past the limit on the side of the operands' sign,
  // so the sign of either addend selects the rail.
  function automatic logic signed [ACC_W-1:0] clamp(input logic neg);
    return neg ? MIN_V : MAX_V;
  endfunction

  assign raw = a + b;

  // Overflow: both addends share a sign and the wrapped sum does not.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  assign sum = (ovf && sat) ? clamp(a[ACC_W-1]) : raw;

endmodule

// File: rtl/m_acc_mac.sv
// m_acc_mac: signed multiply-accumulate over a programmable batch of N terms.
// Two pipeline stages (multiply, accumulate) sit between the operand
// handshake and the result handshake; the result is held until taken.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   bus      : m_acc_mac_if.slave (operand in_*, result out_*)
//   cfg_len  : terms per batch (0 behaves as 1), latched on the first beat
//   cfg_sat  : 1 = saturate, 0 = wrap; latched with cfg_len
//   clear    : synchronous flush of the whole batch
//   busy     : controller active or a product still in flight
module m_acc_mac
  import m_acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  m_acc_mac_if.slave       bus,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_sat,
  input  logic             clear,
  output logic             busy
);

  localparam int PROD_W = 2 * DATA_W;

  state_t state;
  state_t state_next;

  // Batch configuration and term bookkeeping.
  logic [LEN_W-1:0] len_q;
  logic             sat_q;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] acc_cnt;   // beats accepted in this batch
  logic [LEN_W-1:0] sum_cnt;   // products folded into the accumulator
  logic [LEN_W-1:0] sum_cnt_next;

  logic accept;
  logic handshake;

  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;

  logic signed [ACC_W-1:0]  acc_p2;
  logic                     ovf_p2;
  logic                     done_p2;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  add_lhs;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_ovf;

  assign len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  // In IDLE the batch length is not latched yet, but every batch has at least
  // one term, so the first beat is always welcome. Gating with reset keeps
  // the handshake quiet while the block is held in reset.
  assign bus.in_ready = reset & ~clear &
                        ((state == IDLE) | ((state == ACCUM) & (acc_cnt < len_q)));

  assign accept    = bus.in_valid & bus.in_ready;
  assign handshake = (state == HOLD) & bus.out_ready;

  assign bus.out_acc = acc_p2;
  assign bus.out_ovf = ovf_p2;
  assign busy        = (state != IDLE) | vld_p1;

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and result-valid decode.
  always_comb begin
    state_next    = state;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = ACCUM;
      end
      ACCUM: begin
        // done_p2 marks that the last product is already in acc_p2.
        if (done_p2) state_next = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // The first term of a batch replaces the accumulator instead of adding to
  // it, so nothing leaks from a previous batch. With a zero left operand the
  // adder cannot overflow because ACC_W >= 2*DATA_W.
  assign prod_ext     = ACC_W'(prod_p1);
  assign add_lhs      = (sum_cnt == '0) ? '0 : acc_p2;
  assign sum_cnt_next = sum_cnt + LEN_W'(1);

  m_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (add_lhs),
    .b   (prod_ext),
    .sat (sat_q),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      sat_q   <= 1'b0;
      acc_cnt <= '0;
      sum_cnt <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
      done_p2 <= 1'b0;
    end else if (clear) begin
      acc_cnt <= '0;
      sum_cnt <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
      done_p2 <= 1'b0;
    end else begin
      // ---- stage 1: multiply accepted operand pair ----
      vld_p1 <= accept;
      if (accept) begin
        prod_p1 <= PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
        if (state == IDLE) begin
          len_q   <= len_eff;
          sat_q   <= cfg_sat;
          acc_cnt <= LEN_W'(1);
        end else begin
          acc_cnt <= acc_cnt + LEN_W'(1);
        end
      end

      // ---- stage 2: accumulate with overflow tracking ----
      done_p2 <= 1'b0;
      if (vld_p1) begin
        acc_p2  <= add_sum;
        ovf_p2  <= (sum_cnt == '0) ? add_ovf : (ovf_p2 | add_ovf);
        sum_cnt <= sum_cnt_next;
        done_p2 <= (sum_cnt_next == len_q);
      end

      // Result taken: start the next batch from a clean slate.
      if (handshake) begin
        acc_cnt <= '0;
        sum_cnt <= '0;
        acc_p2  <= '0;
        ovf_p2  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_acc_mac.sv
// tb_m_acc_mac: self-checking bench for m_acc_mac.
// Two instances (ACC_W=20 and ACC_W=16) share every input, so both follow the
// same handshake timing while their results differ in range and overflow.
module tb_m_acc_mac;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic [LEN_W-1:0]         cfg_len;
  logic                     cfg_sat;
  logic                     clear;
  logic                     busy20;
  logic                     busy16;

  m_acc_mac_if #(.DATA_W(DATA_W), .ACC_W(20)) if20 ();
  m_acc_mac_if #(.DATA_W(DATA_W), .ACC_W(16)) if16 ();

  assign if20.in_valid  = in_valid;
  assign if20.in_a      = in_a;
  assign if20.in_b      = in_b;
  assign if20.out_ready = out_ready;
  assign if16.in_valid  = in_valid;
  assign if16.in_a      = in_a;
  assign if16.in_b      = in_b;
  assign if16.out_ready = out_ready;

  m_acc_mac #(.DATA_W(DATA_W), .ACC_W(20), .LEN_W(LEN_W)) u20 (
    .clk     (clk),
    .reset   (reset),
    .bus     (if20),
    .cfg_len (cfg_len),
    .cfg_sat (cfg_sat),
    .clear   (clear),
    .busy    (busy20)
  );

  m_acc_mac #(.DATA_W(DATA_W), .ACC_W(16), .LEN_W(LEN_W)) u16 (
    .clk     (clk),
    .reset   (reset),
    .bus     (if16),
    .cfg_len (cfg_len),
    .cfg_sat (cfg_sat),
    .clear   (clear),
    .busy    (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Terms of the batch currently being driven.
  int qa[$];
  int qb[$];

  typedef struct {
    int     n;
    bit     sat;
    int     a[4];
    int     b[4];
    longint e20;
    bit     o20;
    longint e16;
    bit     o16;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide-integer arithmetic, clamping or wrapping after
  // every term whose running sum leaves the w-bit signed range.
  task automatic model(input int w, input bit sat, output longint acc, output bit ovf);
    longint mx;
    longint mn;
    longint s;
    mx  = (64'sd1 <<< (w - 1)) - 1;
    mn  = -(64'sd1 <<< (w - 1));
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      s = acc + longint'(qa[i]) * longint'(qb[i]);
      if (s > mx || s < mn) begin
        ovf = 1'b1;
        if (sat) s = (s > mx) ? mx : mn;
        else     s = (s > mx) ? s - (64'sd1 <<< w) : s + (64'sd1 <<< w);
      end
      acc = s;
    end
  endtask

  // Hold one operand pair on the bus until it transfers (bounded).
  task automatic send_beat(input int a, input int b);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_a     = DATA_W'(a);
    in_b     = DATA_W'(b);
    while (!done) begin
      #2;
      done = if20.in_ready;
      step();
      n++;
      if (!done && n > 50) begin
        check("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  // Drive the terms in qa/qb as one batch, then check latency, hold
  // behaviour, the result of both instances and the post-handshake state.
  task automatic run_batch(input string tag, input int len_cfg, input bit sat,
                           input int bub, input int hold, input bit scramble,
                           input longint e20, input bit o20,
                           input longint e16, input bit o16);
    cfg_len = LEN_W'(len_cfg);
    cfg_sat = sat;
    for (int i = 0; i < qa.size(); i++) begin
      int nb;
      nb = (bub > 0) ? int'($urandom_range(bub, 0)) : 0;
      in_valid = 1'b0;
      repeat (nb) step();
      send_beat(qa[i], qb[i]);
      if (scramble) begin
        cfg_len = LEN_W'($urandom);
        cfg_sat = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check({tag, "_lat0"}, if20.out_valid, 0);
    step();
    check({tag, "_lat1"}, if20.out_valid, 0);
    step();
    check({tag, "_lat2_20"}, if20.out_valid, 1);
    check({tag, "_lat2_16"}, if16.out_valid, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = 8'sd1;
      in_b     = 8'sd1;
      #2;
      check({tag, "_hold_rdy"}, if20.in_ready, 0);
      check({tag, "_hold_vld"}, if20.out_valid, 1);
      check({tag, "_hold_acc"}, if20.out_acc, e20);
      step();
    end
    in_valid = 1'b0;
    check({tag, "_acc20"}, if20.out_acc, e20);
    check({tag, "_ovf20"}, if20.out_ovf, longint'(o20));
    check({tag, "_acc16"}, if16.out_acc, e16);
    check({tag, "_ovf16"}, if16.out_ovf, longint'(o16));
    check({tag, "_busy"}, busy20, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_post_vld"}, if20.out_valid, 0);
    check({tag, "_post_acc"}, if20.out_acc, 0);
    check({tag, "_post_busy"}, busy16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e20;
    longint e16;
    bit     o20;
    bit     o16;

    // Hand-derived vectors: {N, sat, a[], b[], acc20, ovf20, acc16, ovf16}.
    tbl[0] = '{n:4, sat:1'b0, a:'{3, -2, 10, -1},       b:'{5, 7, 10, -1},
               e20:102,    o20:1'b0, e16:102,    o16:1'b0};
    tbl[1] = '{n:3, sat:1'b1, a:'{-128, -128, -128, 0}, b:'{-128, -128, -128, 0},
               e20:49152,  o20:1'b0, e16:32767,  o16:1'b1};
    tbl[2] = '{n:3, sat:1'b0, a:'{-128, -128, -128, 0}, b:'{-128, -128, -128, 0},
               e20:49152,  o20:1'b0, e16:-16384, o16:1'b1};
    tbl[3] = '{n:1, sat:1'b0, a:'{-128, 0, 0, 0},       b:'{127, 0, 0, 0},
               e20:-16256, o20:1'b0, e16:-16256, o16:1'b0};
    tbl[4] = '{n:4, sat:1'b1, a:'{127, 127, 127, 127},  b:'{127, 127, 127, 127},
               e20:64516,  o20:1'b0, e16:32767,  o16:1'b1};
    tbl[5] = '{n:3, sat:1'b1, a:'{-128, -128, -128, 0}, b:'{127, 127, 127, 0},
               e20:-48768, o20:1'b0, e16:-32768, o16:1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    cfg_len   = '0;
    cfg_sat   = 1'b0;
    clear     = 1'b0;

    // Reset state.
    repeat (2) step();
    check("rst_vld", if20.out_valid, 0);
    check("rst_acc", if20.out_acc, 0);
    check("rst_ovf", if20.out_ovf, 0);
    check("rst_busy", busy20, 0);
    reset = 1'b1;
    #2;
    check("rst_rdy20", if20.in_ready, 1);
    check("rst_rdy16", if16.in_ready, 1);
    step();

    // Table-driven batches, back-to-back beats.
    for (int i = 0; i < 6; i++) begin
      qa.delete();
      qb.delete();
      for (int j = 0; j < tbl[i].n; j++) begin
        qa.push_back(tbl[i].a[j]);
        qb.push_back(tbl[i].b[j]);
      end
      run_batch($sformatf("vec%0d", i), tbl[i].n, tbl[i].sat, 0, 0, 1'b0,
                tbl[i].e20, tbl[i].o20, tbl[i].e16, tbl[i].o16);
    end

    // Result held under back-pressure, then a fresh single-term batch.
    qa = '{4, 2};
    qb = '{4, 3};
    run_batch("hold", 2, 1'b0, 0, 5, 1'b0, 22, 1'b0, 22, 1'b0);
    qa = '{1};
    qb = '{1};
    run_batch("fresh", 1, 1'b0, 0, 0, 1'b0, 1, 1'b0, 1, 1'b0);

    // Clear after two accepted beats of a four-term batch.
    cfg_len = 8'd4;
    cfg_sat = 1'b0;
    send_beat(1, 2);
    send_beat(3, 4);
    in_a  = 8'sd5;
    in_b  = 8'sd5;
    clear = 1'b1;
    #2;
    check("clr_rdy", if20.in_ready, 0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("clr_vld", if20.out_valid, 0);
      check("clr_acc", if20.out_acc, 0);
      check("clr_busy", busy20, 0);
      step();
    end
    qa = '{4};
    qb = '{4};
    run_batch("after_clr", 1, 1'b0, 0, 0, 1'b0, 16, 1'b0, 16, 1'b0);

    // cfg_len=0 acts as one term; reset arrives while the result is held.
    cfg_len  = '0;
    cfg_sat  = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    send_beat(7, -3);
    in_valid = 1'b0;
    step();
    step();
    check("len0_vld", if20.out_valid, 1);
    check("len0_acc20", if20.out_acc, -21);
    check("len0_acc16", if16.out_acc, -21);
    #3;
    reset = 1'b0;
    #1;
    check("arst_vld", if20.out_valid, 0);
    check("arst_acc20", if20.out_acc, 0);
    check("arst_acc16", if16.out_acc, 0);
    check("arst_ovf", if20.out_ovf, 0);
    check("arst_busy", busy20, 0);
    check("arst_rdy", if20.in_ready, 0);
    step();
    reset = 1'b1;
    #2;
    check("rel_rdy", if20.in_ready, 1);
    check("rel_vld", if20.out_valid, 0);
    step();

    // Randomized batches against the reference model, with bubbles,
    // back-pressure and configuration churn after the first beat.
    for (int r = 0; r < 40; r++) begin
      int n;
      bit sat;
      int hold;
      n    = int'($urandom_range(6, 0));
      sat  = 1'($urandom);
      hold = int'($urandom_range(3, 0));
      qa.delete();
      qb.delete();
      for (int j = 0; j < ((n == 0) ? 1 : n); j++) begin
        if ($urandom_range(3, 0) == 0) begin
          qa.push_back(($urandom_range(1, 0) == 0) ? -128 : 127);
          qb.push_back(($urandom_range(1, 0) == 0) ? -128 : 127);
        end else begin
          qa.push_back(int'($urandom_range(255, 0)) - 128);
          qb.push_back(int'($urandom_range(255, 0)) - 128);
        end
      end
      model(20, sat, e20, o20);
      model(16, sat, e16, o16);
      run_batch($sformatf("rnd%0d", r), n, sat, 2, hold, 1'b1, e20, o20, e16, o16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_acc_mac.md
Name: m_acc_mac

Overview:
Parametrised successor to the MPU 8-bit adder-accumulator. Performs a signed multiply-accumulate over a programmable number of terms (dot-product length N) and returns the result through a valid/ready handshake. A 2-stage pipeline (multiply, then accumulate) sits between the operand source and the MPU result writeback. Optional saturation and a sticky overflow flag are included.

Parameters:
DATA_W, 8, width of signed operands in_a/in_b
ACC_W, 20, width of signed accumulator/result; must be >= 2*DATA_W
LEN_W, 8, width of cfg_len (max terms per batch = 2^LEN_W - 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operand pair
in_a  in  DATA_W  signed operand A
in_b  in  DATA_W  signed operand B
cfg_len  in  LEN_W  terms per batch N; sampled on first accepted beat of a batch; 0 treated as 1
cfg_sat  in  1  1 = saturate on overflow, 0 = two's-complement wrap; sampled with cfg_len
clear  in  1  synchronous abort/flush, highest priority after reset
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_acc  out  ACC_W  signed accumulated result
out_ovf  out  1  sticky: overflow occurred in this batch
busy  out  1  state != IDLE or pipeline not empty

Behaviour:
- Reset (reset=0, async): state=IDLE, all pipeline regs, acc, term counters, out_valid, out_acc, out_ovf and busy = 0. in_ready=1 once reset releases.
- Accept: a beat transfers when in_valid & in_ready. in_ready = (state in IDLE/ACCUM) & (accepted_cnt < N) & ~clear.
- FSM:
  IDLE -> ACCUM on first accepted beat; latch N and sat mode.
  ACCUM -> HOLD when the Nth product has been accumulated.
  HOLD -> IDLE on out_valid & out_ready.
- Stage 1: prod <= signed(in_a)*signed(in_b), 2*DATA_W bits, p_vld <= accept.
- Stage 2, on p_vld: the first term of a batch loads acc <= sext(prod), with no dependence on the previous batch. Later terms load acc <= acc + sext(prod).
- Overflow: signed overflow of the ACC_W addition sets out_ovf, which stays set until the batch ends.
  - sat=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - sat=0: wrap.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+2. Input bubbles are allowed and only stretch the batch.
- HOLD: out_valid=1 and out_acc/out_ovf stay stable until handshake. in_ready=0. After handshake, acc and ovf are treated as cleared and out_valid=0 next cycle.
- clear=1: at the next edge, go to IDLE, drop the in-flight product, zero counters/acc/out_ovf, out_valid=0. A beat presented in the same cycle is not accepted.
- Reset asserted mid-batch or in HOLD: immediate return to reset values, with no partial result output.
- cfg_len/cfg_sat changes mid-batch are ignored.

Decomposition:
- Package m_acc_pkg: state enum (IDLE, ACCUM, HOLD), and functions sat_max(ACC_W)/sat_min(ACC_W).
- Sub-module m_sat_add: combinational ACC_W signed adder with sat-mode input, producing sum and overflow outputs. It is instantiated once in stage 2.

Test Plan:
1. DATA_W=8, ACC_W=20, N=4, back-to-back (3,5),(-2,7),(10,10),(-1,-1) -> out_valid 2 cycles after last accept, out_acc=102, out_ovf=0.
2. ACC_W=16, N=3, three beats of (-128,-128):
   - sat=1 -> out_acc=32767, ovf=1.
   - sat=0 -> out_acc=0xC000 (-16384), ovf=1.
3. N=2, (4,4),(2,3), out_ready held low 5 cycles -> out_acc=22 stable and in_ready=0 throughout. After handshake, a new batch N=1 (1,1) returns 1, showing no carry-over.
4. N=4, clear pulsed after 2 accepted beats -> out_valid never rises. The next batch N=1 (4,4) -> out_acc=16, ovf=0.
5. cfg_len=0 with beat (7,-3) and in_valid bubbles, then reset pulsed while in HOLD -> out_acc=-21 seen first. On reset all outputs go 0 asynchronously, and in_ready=1 after release.
